// File: rtl/mem_ctrl_ws_if.sv
// mem_ctrl_ws_if: request/response bus between a requester and mem_ctrl_ws.
// master drives requests; slave accepts them and returns one-cycle responses.
interface mem_ctrl_ws_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/mem_ctrl_ws.sv
// mem_ctrl_ws: single-port RAM controller with read/write wait states.
// Define MEM_CTRL_ACCESS_COUNT_EN to add saturating rd_count/wr_count outputs.
module mem_ctrl_ws #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                READ_WAIT   = 1,
    parameter int                WRITE_WAIT  = 0
) (
    input  logic         clk,
    input  logic         rst,
    mem_ctrl_ws_if.slave bus,
    output logic         busy
`ifdef MEM_CTRL_ACCESS_COUNT_EN
    ,
    output logic [31:0]  rd_count,
    output logic [31:0]  wr_count
`endif
);
    localparam int NB    = DATA_W / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [63:0]       SPAN  = 64'(DEPTH_WORDS) * 64'(NB);
    localparam logic [ADDR_W-1:0] ALIGN = ADDR_W'(NB - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t st, nxt;
    logic [3:0]        cnt, cnt_nxt, req_wait;
    logic              lat_write, err_q;
    logic [IDX_W-1:0]  lat_idx;
    logic [DATA_W-1:0] lat_wdata;
    logic [NB-1:0]     lat_be;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic [ADDR_W-1:0] off;
    logic              bad, accept, do_acc, acc_write;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] acc_wdata;
    logic [NB-1:0]     acc_be;

    // Unsigned wrap makes addresses below BASE_ADDR land out of range.
    assign off      = bus.req_addr - BASE_ADDR;
    assign bad      = (|(bus.req_addr & ALIGN)) || (64'(off) >= SPAN);
    assign req_wait = bus.req_write ? 4'(WRITE_WAIT) : 4'(READ_WAIT);
    assign accept   = (st == IDLE) && bus.req_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= IDLE;
            cnt <= '0;
        end else begin
            st  <= nxt;
            cnt <= cnt_nxt;
        end
    end

    always_comb begin
        nxt       = st;
        cnt_nxt   = cnt;
        do_acc    = 1'b0;
        acc_write = lat_write;
        acc_idx   = lat_idx;
        acc_wdata = lat_wdata;
        acc_be    = lat_be;
        unique case (st)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bad) begin
                        nxt = RESP;
                    end else if (req_wait == 4'd0) begin
                        do_acc    = 1'b1;
                        acc_write = bus.req_write;
                        acc_idx   = off[LSB +: IDX_W];
                        acc_wdata = bus.req_wdata;
                        acc_be    = bus.req_be;
                        nxt       = RESP;
                    end else begin
                        cnt_nxt = req_wait;
                        nxt     = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    do_acc = 1'b1;
                    nxt    = RESP;
                end
            end
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_write <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                lat_write <= bus.req_write;
                lat_idx   <= off[LSB +: IDX_W];
                lat_wdata <= bus.req_wdata;
                lat_be    <= bus.req_be;
                err_q     <= bad;
            end
            if (do_acc && !acc_write) begin
                rdata_q <= mem[acc_idx];
            end else if (st == RESP) begin
                rdata_q <= '0;
            end
        end
    end

    // RAM has no reset; a reset edge blocks any pending commit.
    always_ff @(posedge clk) begin
        if (!rst && do_acc && acc_write) begin
            for (int b = 0; b < NB; b++) begin
                if (acc_be[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (st == IDLE);
    assign bus.rsp_valid = (st == RESP);
    assign bus.rsp_error = (st == RESP) && err_q;
    assign bus.rsp_rdata = rdata_q;
    assign busy          = (st != IDLE);

`ifdef MEM_CTRL_ACCESS_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (st == RESP && !err_q) begin
            if (lat_write) begin
                if (wr_count != '1) wr_count <= wr_count + 32'd1;
            end else begin
                if (rd_count != '1) rd_count <= rd_count + 32'd1;
            end
        end
    end
`endif
endmodule

// File: doc/mem_ctrl_ws.md
Name: mem_ctrl_ws

Overview:
Parametrised single-port synchronous memory controller. Successor to the fixed-width CPU memory path: configurable width, depth, base address and read/write wait states. Adds a valid/ready request handshake, byte-lane writes and an error response for misaligned or out-of-range accesses. Sits between the CPU core's memory bus and an inferred word-addressed RAM inside the MCU top.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width in bits; multiple of 8, power of 2, at least 8.
- DEPTH_WORDS, 1024, number of DATA_W words stored; power of 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DATA_W/8.
- READ_WAIT, 1, extra wait cycles per read (0..15).
- WRITE_WAIT, 0, extra wait cycles per write (0..15).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data, little-endian lanes.
- req_be  in  DATA_W/8  byte enables; bit i selects bits [8i+7:8i].
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid.
- rsp_error  out  1  access error; valid with rsp_valid.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset values:
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0.
  - FSM goes to IDLE; wait counter = 0.
  - RAM contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch write, addr, wdata and be, then check the address.
  - Error when either holds: addr low log2(DATA_W/8) bits are nonzero; (addr - BASE_ADDR) is outside [0, DEPTH_WORDS*DATA_W/8), with the subtraction done unsigned at ADDR_W width so an addr below BASE wraps and also errors.
  - Error -> go to RESP.
  - No error, wait count 0 -> perform the access and go to RESP.
  - No error, wait count > 0 -> load the counter with that count and go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - On the cycle the counter reaches 1, perform the access and go to RESP.
- Access:
  - A write updates only the lanes whose be bit is set.
  - A read captures the full word into rsp_rdata.
  - A write with be=0 is legal: no RAM change, no error.
- RESP:
  - rsp_valid=1 for exactly one cycle; there is no response backpressure.
  - rsp_error is set for an errored request. In that case: no RAM change; rsp_rdata=0.
  - rsp_rdata=0 for writes.
  - Next state is IDLE.
- rsp_valid, rsp_rdata and rsp_error return to 0 the cycle after RESP.
- Latency:
  - Request accepted at edge T -> rsp_valid high during cycle T+1+W. W = READ_WAIT or WRITE_WAIT; W = 0 for errored requests.
  - Back-to-back throughput is one request per 2+W cycles.
- req_valid with req_ready=0 is ignored. The requester must hold the request until it is accepted.
- Read-after-write to the same address in consecutive transactions returns the new data.
- Reset mid-operation:
  - In WAIT, an uncommitted write is dropped.
  - The pending response is discarded; outputs take their reset values on the next edge.

Optional Feature:
MEM_CTRL_ACCESS_COUNT_EN
- Defined:
  - Adds outputs rd_count[31:0] and wr_count[31:0].
  - Each increments on a successful (non-error) access, in the RESP cycle.
  - Both saturate at 32'hFFFF_FFFF.
  - Both reset to 0.
  - Errored requests are not counted.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
Defaults apply (DATA_W=32, DEPTH_WORDS=1024, BASE_ADDR=0, READ_WAIT=1, WRITE_WAIT=0).
- Write addr 0x10, data 0xDEADBEEF, be=4'hF, then read 0x10 -> write rsp 1 cycle after accept with error=0; read rsp 2 cycles after accept, rdata=0xDEADBEEF.
- Write 0x10, data 0x000000AA, be=4'b0001, then read 0x10 -> rdata=0xDEADBEAA.
- Read 0x12 (misaligned), then write 0x1000 (out of range) -> each gives rsp_error=1 one cycle after accept, rdata=0; a later read of 0x10 is unchanged.
- Hold req_valid high with back-to-back reads -> req_ready low in WAIT and RESP; one acceptance every 3 cycles; no request lost or duplicated.
- Assert rst during WAIT of a read to 0x20 -> no rsp_valid; req_ready=1 the next cycle; RAM unchanged.
- With MEM_CTRL_ACCESS_COUNT_EN: 3 good reads, 2 good writes, 1 error -> rd_count=3, wr_count=2.
